// File: rtl/uart_rx_port.sv
// 8N1 UART receiver into a one-byte holding register; data_valid ~2+9.5*CLKS_PER_BIT cycles after start edge.
// No backpressure on the line: a byte completing while the register is still unread is dropped and flagged as overrun.
module uart_rx_port #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       rd_ack,
    output logic [7:0] uart_read_byte,
    output logic       data_valid,
    output logic       int_req,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_rx_meta;
    logic              r_rx_s;
    logic [TICK_W-1:0] r_tick;
    logic [TICK_W-1:0] w_tick_nxt;
    logic [2:0]        r_bit;
    logic [2:0]        w_bit_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic              r_deliver;
    logic              w_deliver;
    logic              w_ferr_set;
    logic [7:0]        r_byte;
    logic              r_dv;
    logic              r_ferr;
    logic              r_ovr;

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick + TICK_W'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_deliver   = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tick_nxt = '0;
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                // Mid start bit: a line that is high again was only a glitch.
                if (r_tick == TICK_MID) begin
                    w_tick_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_tick == TICK_LAST) begin
                    w_tick_nxt  = '0;
                    w_shift_nxt = {r_rx_s, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_tick == TICK_LAST) begin
                    w_tick_nxt = '0;
                    if (r_rx_s) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr_set  = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                w_tick_nxt = '0;
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_tick_nxt  = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_bit     <= 3'd0;
            r_shift   <= 8'h00;
            r_deliver <= 1'b0;
            r_byte    <= 8'h00;
            r_dv      <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_s    <= r_rx_meta;
            r_state   <= w_state_nxt;
            r_tick    <= w_tick_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_deliver <= w_deliver;

            if (rd_ack && r_dv) begin
                r_dv   <= 1'b0;
                r_ferr <= 1'b0;
                r_ovr  <= 1'b0;
            end
            if (w_ferr_set) begin
                r_ferr <= 1'b1;
            end
            // An ack landing in the delivery cycle frees the register for the new byte.
            if (r_deliver) begin
                if (!r_dv || rd_ack) begin
                    r_byte <= r_shift;
                    r_dv   <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end
        end
    end

    assign uart_read_byte = r_byte;
    assign data_valid     = r_dv;
    assign int_req        = r_dv;
    assign frame_err      = r_ferr;
    assign overrun        = r_ovr;

endmodule
